ir_key_event_ctrl: RTL and testbench
====================================

// Module: ir_key_event_ctrl
// PURPOSE
//  Turns raw NEC decoder results into key events for firmware/UI logic: PRESS, HOLD, REPEAT, RELEASE.
//  Sits between the NEC decoder (8-bit command, valid pulse, repeat flag) and the consumer.
//  Tracks key-down state with ms timers and schedules auto-repeat.
//  Events are buffered in a small FWFT FIFO with a valid/ready handshake.
// PARAMETERS
//  CLK_FREQ    50_000_000  system clock in Hz; 1 ms tick = CLK_FREQ/1000 clocks
//  RELEASE_MS  120         ms with no frame/repeat before a held key is declared released
//  HOLD_MS     500         ms after PRESS before HOLD is emitted
//  RPT_MS      200         auto-repeat period while in HELD
//  FIFO_DEPTH  4           event FIFO entries (power of 2, >=2)
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous, active-low reset
//  key_code    in   8  decoded command from NEC decoder
//  key_valid   in   1  1-cycle pulse: full frame decoded, key_code valid
//  key_repeat  in   1  repeat-frame flag (may be >1 cycle wide); rising edge = one repeat frame
//  evt_valid   out  1  FIFO head valid
//  evt_ready   in   1  consumer accepts head when evt_valid & evt_ready
//  evt_type    out  2  00 PRESS, 01 HOLD, 10 REPEAT, 11 RELEASE
//  evt_code    out  8  key code of the event
//  key_down    out  1  high in DOWN, HELD and SWAP states
//  overflow    out  1  1-cycle pulse: event dropped because FIFO full
// BEHAVIOUR
//  Reset (async): FSM=IDLE; timers, prescaler and FIFO cleared; all outputs 0; no RELEASE emitted.
//  Prescaler is free-running and produces a 1-clk ms_tick. Timer accuracy is -1 ms/+0.
//  rel_cnt and hold_cnt count ms_tick and saturate. "Refresh" sets rel_cnt=0.
//  rep_edge = key_repeat & ~key_repeat_d1, where key_repeat_d1 is registered.
//  FSM (cur_code = latched code):
//   IDLE : key_valid -> cur_code<=key_code, push PRESS, rel_cnt=hold_cnt=0, ->DOWN.
//          rep_edge is ignored.
//   DOWN : key_valid & same code, or rep_edge -> refresh.
//          key_valid & different code -> push RELEASE(cur_code), store new code, ->SWAP.
//          rel_cnt==RELEASE_MS -> push RELEASE, ->IDLE.
//          hold_cnt==HOLD_MS -> push HOLD, hold_cnt=0, ->HELD.
//   HELD : same refresh and different-code rules as DOWN.
//          rel_cnt==RELEASE_MS -> push RELEASE, ->IDLE.
//          hold_cnt==RPT_MS -> push REPEAT, hold_cnt=0.
//   SWAP : one cycle -> cur_code<=stored code, push PRESS, rel_cnt=hold_cnt=0, ->DOWN.
//          Inputs arriving in this cycle are ignored.
//  Same-cycle priority: key_valid > rep_edge > release timeout > hold/repeat timer.
//   If refresh and timeout coincide, refresh wins and no RELEASE is emitted.
//  At most one push per cycle.
//  FIFO:
//   - Entry = {type,code}. evt_* show the head combinationally from registers.
//   - key_valid at cycle N gives evt_valid=1 at N+1 if the FIFO was empty.
//   - Pop on evt_valid & evt_ready. Push when full with no pop in the same cycle -> entry dropped, overflow=1.
//   - Push and pop in the same cycle while full: both succeed, count unchanged.
//   - Pop while empty is ignored. Pointers wrap modulo FIFO_DEPTH; count width is clog2(DEPTH)+1.
//   - FSM advances regardless of drops; evt_ready never stalls the FSM.
// TESTING
//  Bench uses CLK_FREQ=10_000 (1 ms = 10 clk), defaults otherwise, evt_ready=1 unless stated.
//  1 Tap: key_valid code 0x45, no repeats -> PRESS 0x45 next cycle; RELEASE 0x45 ~120 ms later; no HOLD.
//  2 Long press: 0x16 then rep_edge every 108 ms for 1000 ms -> PRESS@0, HOLD@500, REPEAT@700,900,
//    then RELEASE ~120 ms after the last repeat.
//  3 Key swap: 0x0C, then 0x18 at 50 ms -> PRESS 0C, RELEASE 0C, PRESS 18 on consecutive cycles;
//    key_down stays 1.
//  4 Backpressure: evt_ready=0, generate 6 events -> 4 stored, overflow pulses twice.
//    Release evt_ready -> 4 events out in order.
//  5 Full with simultaneous push+pop: no overflow, count stays 4.
//  6 rst_n low in HELD -> outputs 0 immediately; after release, no events until a new key_valid.

Source files
------------

// File: rtl/ir_key_event_ctrl.sv
// rtl/ir_key_event_ctrl.sv - NEC key results to PRESS/HOLD/REPEAT/RELEASE events via FWFT FIFO
module ir_key_event_ctrl #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int RELEASE_MS = 120,
    parameter int HOLD_MS    = 500,
    parameter int RPT_MS     = 200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key_code,
    input  logic       key_valid,
    input  logic       key_repeat,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_type,
    output logic [7:0] evt_code,
    output logic       key_down,
    output logic       overflow
);

    localparam int TICK_DIV = CLK_FREQ / 1000;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_A    = (RELEASE_MS > HOLD_MS) ? RELEASE_MS : HOLD_MS;
    localparam int MAX_MS   = (MAX_A > RPT_MS) ? MAX_A : RPT_MS;
    localparam int MS_W     = $clog2(MAX_MS + 1);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DOWN = 2'd1;
    localparam logic [1:0] ST_HELD = 2'd2;
    localparam logic [1:0] ST_SWAP = 2'd3;

    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_HOLD    = 2'b01;
    localparam logic [1:0] EVT_REPEAT  = 2'b10;
    localparam logic [1:0] EVT_RELEASE = 2'b11;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [MS_W-1:0]  REL_LIM  = MS_W'(RELEASE_MS);
    localparam logic [MS_W-1:0]  HOLD_LIM = MS_W'(HOLD_MS);
    localparam logic [MS_W-1:0]  RPT_LIM  = MS_W'(RPT_MS);
    localparam logic [MS_W-1:0]  MS_SAT   = '1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [PRE_W-1:0] pre_cnt;
    logic             ms_tick;
    logic             rep_d1;
    logic             rep_edge;

    logic [1:0]       state,     state_nxt;
    logic [7:0]       cur_code,  cur_nxt;
    logic [7:0]       swap_code, swap_nxt;
    logic [MS_W-1:0]  rel_cnt,   rel_nxt;
    logic [MS_W-1:0]  hold_cnt,  hold_nxt;
    logic             refresh;

    logic             push;
    logic [1:0]       push_type;
    logic [7:0]       push_code;

    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             pop;
    logic             full;
    logic             drop;
    logic             wr_en;
    logic [9:0]       head;

    assign ms_tick  = (pre_cnt == PRE_LAST);
    assign rep_edge = key_repeat & ~rep_d1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            rep_d1  <= 1'b0;
        end else begin
            pre_cnt <= ms_tick ? '0 : pre_cnt + PRE_W'(1);
            rep_d1  <= key_repeat;
        end
    end

    // A full frame overrides a repeat edge; a mismatching frame is a swap, not a refresh.
    assign refresh = key_valid ? (key_code == cur_code) : rep_edge;

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur_code;
        swap_nxt  = swap_code;
        rel_nxt   = (ms_tick && rel_cnt != MS_SAT) ? rel_cnt + MS_W'(1) : rel_cnt;
        hold_nxt  = (ms_tick && hold_cnt != MS_SAT) ? hold_cnt + MS_W'(1) : hold_cnt;
        push      = 1'b0;
        push_type = EVT_PRESS;
        push_code = cur_code;
        case (state)
            ST_IDLE: begin
                if (key_valid) begin
                    cur_nxt   = key_code;
                    push      = 1'b1;
                    push_code = key_code;
                    rel_nxt   = '0;
                    hold_nxt  = '0;
                    state_nxt = ST_DOWN;
                end
            end
            ST_DOWN, ST_HELD: begin
                if (refresh) begin
                    rel_nxt = '0;
                end else if (key_valid) begin
                    push      = 1'b1;
                    push_type = EVT_RELEASE;
                    swap_nxt  = key_code;
                    state_nxt = ST_SWAP;
                end else if (rel_cnt >= REL_LIM) begin
                    push      = 1'b1;
                    push_type = EVT_RELEASE;
                    state_nxt = ST_IDLE;
                end else if (state == ST_DOWN && hold_cnt >= HOLD_LIM) begin
                    push      = 1'b1;
                    push_type = EVT_HOLD;
                    hold_nxt  = '0;
                    state_nxt = ST_HELD;
                end else if (state == ST_HELD && hold_cnt >= RPT_LIM) begin
                    push      = 1'b1;
                    push_type = EVT_REPEAT;
                    hold_nxt  = '0;
                end
            end
            ST_SWAP: begin
                cur_nxt   = swap_code;
                push      = 1'b1;
                push_code = swap_code;
                rel_nxt   = '0;
                hold_nxt  = '0;
                state_nxt = ST_DOWN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cur_code  <= '0;
            swap_code <= '0;
            rel_cnt   <= '0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            cur_code  <= cur_nxt;
            swap_code <= swap_nxt;
            rel_cnt   <= rel_nxt;
            hold_cnt  <= hold_nxt;
        end
    end

    assign key_down = (state != ST_IDLE);

    // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
    assign pop   = evt_valid & evt_ready;
    assign full  = (count == CNT_FULL);
    assign drop  = push & full & ~pop;
    assign wr_en = push & ~drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= drop;
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {push_type, push_code};
    end

    assign head      = mem[rd_ptr];
    assign evt_valid = (count != '0);
    assign evt_type  = evt_valid ? head[9:8] : 2'b00;
    assign evt_code  = evt_valid ? head[7:0] : 8'h00;

endmodule

// File: tb/tb_ir_key_event_ctrl.sv
// tb/tb_ir_key_event_ctrl.sv - directed and random stimulus against an event-level reference model
module tb_ir_key_event_ctrl;

    localparam int DIV   = 10;
    localparam int REL   = 120;
    localparam int HOLD  = 500;
    localparam int RPT   = 200;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       key_valid = 1'b0;
    logic       key_repeat = 1'b0;
    logic       evt_ready = 1'b1;
    logic       evt_valid;
    logic [1:0] evt_type;
    logic [7:0] evt_code;
    logic       key_down;
    logic       overflow;

    always #5 clk = ~clk;

    ir_key_event_ctrl #(
        .CLK_FREQ   (10_000),
        .RELEASE_MS (REL),
        .HOLD_MS    (HOLD),
        .RPT_MS     (RPT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_repeat (key_repeat),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_type   (evt_type),
        .evt_code   (evt_code),
        .key_down   (key_down),
        .overflow   (overflow)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: key pressed/held flags, ms elapsed since refresh and since press/hold/repeat.
    bit         m_down, m_held, m_swap, m_rep_prev, m_ovf;
    logic [7:0] m_code, m_next;
    int         m_quiet, m_phase, m_cyc;
    logic [9:0] m_fifo[$];

    logic [9:0] obs_q[$];
    int         ovf_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_down = 0; m_held = 0; m_swap = 0; m_rep_prev = 0; m_ovf = 0;
        m_code = 8'h00; m_next = 8'h00;
        m_quiet = 0; m_phase = 0; m_cyc = 0;
        m_fifo.delete();
    endfunction

    function automatic void model_step();
        bit         tick, rep_edge, pop, full, push, same;
        logic [9:0] pv;
        int         qn, pn;
        m_cyc++;
        tick     = (m_cyc % DIV) == 0;
        rep_edge = key_repeat && !m_rep_prev;
        m_rep_prev = key_repeat;
        pop  = (m_fifo.size() > 0) && evt_ready;
        full = (m_fifo.size() == DEPTH);
        push = 0;
        pv   = 10'h000;
        qn   = m_quiet + int'(tick);
        pn   = m_phase + int'(tick);
        same = key_valid ? (key_code == m_code) : rep_edge;
        if (m_swap) begin
            push = 1; pv = {2'b00, m_next}; m_code = m_next; m_swap = 0; qn = 0; pn = 0;
        end else if (!m_down) begin
            if (key_valid) begin
                push = 1; pv = {2'b00, key_code}; m_code = key_code;
                m_down = 1; m_held = 0; qn = 0; pn = 0;
            end
        end else if (same) begin
            qn = 0;
        end else if (key_valid) begin
            push = 1; pv = {2'b11, m_code}; m_next = key_code; m_swap = 1; m_held = 0;
        end else if (m_quiet >= REL) begin
            push = 1; pv = {2'b11, m_code}; m_down = 0; m_held = 0;
        end else if (!m_held && m_phase >= HOLD) begin
            push = 1; pv = {2'b01, m_code}; m_held = 1; pn = 0;
        end else if (m_held && m_phase >= RPT) begin
            push = 1; pv = {2'b10, m_code}; pn = 0;
        end
        m_quiet = qn;
        m_phase = pn;
        m_ovf   = push && full && !pop;
        if (pop) void'(m_fifo.pop_front());
        if (push && !m_ovf) m_fifo.push_back(pv);
    endfunction

    task automatic compare_outputs();
        logic [9:0] h;
        h = (m_fifo.size() > 0) ? m_fifo[0] : 10'h000;
        check("evt_valid", evt_valid, m_fifo.size() > 0);
        check("evt_type", evt_type, h[9:8]);
        check("evt_code", evt_code, h[7:0]);
        check("key_down", key_down, m_down);
        check("overflow", overflow, m_ovf);
        if (overflow) ovf_seen++;
    endtask

    task automatic cycle();
        model_step();
        if (evt_valid && evt_ready) obs_q.push_back({evt_type, evt_code});
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic press(input logic [7:0] c);
        key_code  = c;
        key_valid = 1'b1;
        cycle();
        key_valid = 1'b0;
    endtask

    task automatic rep_pulse();
        key_repeat = 1'b1;
        cycle();
        cycle();
        key_repeat = 1'b0;
    endtask

    task automatic check_obs(input string tag, input int idx, input logic [9:0] exp);
        logic [31:0] v;
        v = 'x;
        if (idx < obs_q.size()) v = 32'(obs_q[idx]);
        check(tag, v, 32'(exp));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, evt_valid, 0);
        check({tag, "_type"}, evt_type, 0);
        check({tag, "_code"}, evt_code, 0);
        check({tag, "_down"}, key_down, 0);
        check({tag, "_ovf"}, overflow, 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Tap
        obs_q.delete();
        press(8'h45);
        check("t1_press_next", {evt_valid, evt_type, evt_code}, {1'b1, 2'b00, 8'h45});
        run(1300);
        check("t1_count", obs_q.size(), 2);
        check_obs("t1_ev0", 0, {2'b00, 8'h45});
        check_obs("t1_ev1", 1, {2'b11, 8'h45});

        // Long press with repeat frames every 108 ms
        obs_q.delete();
        press(8'h16);
        for (int i = 0; i < 9; i++) begin
            run(1078);
            rep_pulse();
        end
        run(1500);
        check("t2_count", obs_q.size(), 5);
        check_obs("t2_press", 0, {2'b00, 8'h16});
        check_obs("t2_hold", 1, {2'b01, 8'h16});
        check_obs("t2_rep1", 2, {2'b10, 8'h16});
        check_obs("t2_rep2", 3, {2'b10, 8'h16});
        check_obs("t2_rel", 4, {2'b11, 8'h16});

        // Key swap
        obs_q.delete();
        press(8'h0C);
        run(500);
        press(8'h18);
        check("t3_down_swap", key_down, 1);
        cycle();
        check("t3_down_after", key_down, 1);
        run(3);
        check_obs("t3_ev0", 0, {2'b00, 8'h0C});
        check_obs("t3_ev1", 1, {2'b11, 8'h0C});
        check_obs("t3_ev2", 2, {2'b00, 8'h18});
        run(1300);
        check("t3_count", obs_q.size(), 4);

        // Backpressure: six events into a four-entry FIFO
        evt_ready = 1'b0;
        ovf_seen  = 0;
        obs_q.delete();
        press(8'hA1); run(3);
        press(8'hB2); run(3);
        press(8'hC3); run(3);
        run(1300);
        check("t4_ovf_pulses", ovf_seen, 2);
        check("t4_valid", evt_valid, 1);
        evt_ready = 1'b1;
        run(6);
        check("t4_count", obs_q.size(), 4);
        check_obs("t4_ev0", 0, {2'b00, 8'hA1});
        check_obs("t4_ev1", 1, {2'b11, 8'hA1});
        check_obs("t4_ev2", 2, {2'b00, 8'hB2});
        check_obs("t4_ev3", 3, {2'b11, 8'hB2});

        // Full FIFO with push and pop in the same cycle
        evt_ready = 1'b0;
        ovf_seen  = 0;
        obs_q.delete();
        press(8'h21); run(3);
        press(8'h22); run(3);
        press(8'h23);
        evt_ready = 1'b1;
        cycle();
        evt_ready = 1'b0;
        check("t5_no_ovf", ovf_seen, 0);
        check("t5_one_popped", obs_q.size(), 1);
        run(2);
        evt_ready = 1'b1;
        run(6);
        check("t5_count", obs_q.size(), 5);
        check_obs("t5_ev4", 4, {2'b00, 8'h23});

        // Reset while HELD
        obs_q.delete();
        press(8'h5A);
        for (int i = 0; i < 6; i++) begin
            run(998);
            rep_pulse();
        end
        check("t6_hold_seen", obs_q.size(), 3);
        check_obs("t6_hold", 2, {2'b01, 8'h5A});
        check("t6_down", key_down, 1);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("t6_async");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        obs_q.delete();
        for (int i = 0; i < 30; i++) begin
            key_repeat = 1'b1; run(5);
            key_repeat = 1'b0; run(5);
        end
        check("t6_no_events", obs_q.size(), 0);
        check("t6_idle", key_down, 0);

        // Random traffic: dense, then sparse with heavy backpressure
        for (int i = 0; i < 2000; i++) begin
            key_valid = ($urandom_range(0, 199) == 0);
            key_code  = 8'h10 + 8'($urandom_range(0, 2));
            if ($urandom_range(0, 99) == 0) key_repeat = ~key_repeat;
            evt_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        for (int i = 0; i < 3000; i++) begin
            key_valid = ($urandom_range(0, 999) == 0);
            key_code  = 8'h10 + 8'($urandom_range(0, 2));
            if ($urandom_range(0, 399) == 0) key_repeat = ~key_repeat;
            evt_ready = ($urandom_range(0, 7) == 0);
            cycle();
        end
        key_valid = 1'b0;
        evt_ready = 1'b1;
        run(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
